// File: rtl/sam_result_stage_if.sv
// rtl/sam_result_stage_if.sv - handshake bundle between multiplier, result stage and sink
// Carries the product-in and result-out valid/ready channels of the result stage.
interface sam_result_stage_if #(
   parameter int MAG_W = 64,
   parameter int OUT_W = 64
);
   logic             in_valid;
   logic             in_ready;
   logic             in_sign;
   logic [MAG_W-1:0] in_mag;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_sat;

   modport slave (
      input  in_valid, in_sign, in_mag, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );

   modport master (
      output in_valid, in_sign, in_mag, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/sam_result_stage.sv
// rtl/sam_result_stage.sv - sign-magnitude to saturated two's complement result FIFO
// Converts each accepted product on push and stores it with its saturation flag.
module sam_result_stage #(
   parameter int MAG_W = 64,
   parameter int OUT_W = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   sam_result_stage_if.slave        bus,
   output logic [15:0]              sat_count,
   output logic [$clog2(DEPTH):0]   occupancy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic signed [MAG_W:0] MAX_V = {{(MAG_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [MAG_W:0] MIN_V = {{(MAG_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

   logic [OUT_W-1:0]  data_mem [DEPTH];
   logic [DEPTH-1:0]  sat_mem;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push;
   logic              pop;
   logic signed [MAG_W:0] v;
   logic [OUT_W-1:0]  conv_data;
   logic              conv_sat;

   assign bus.in_ready  = !rst && (occupancy != FULL);
   assign bus.out_valid = (occupancy != '0);
   assign bus.out_data  = bus.out_valid ? data_mem[rd_ptr] : '0;
   assign bus.out_sat   = bus.out_valid & sat_mem[rd_ptr];
   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   // One extra bit keeps -in_mag exact, so negative zero folds to 0 naturally.
   always_comb begin
      v         = bus.in_sign ? -$signed({1'b0, bus.in_mag}) : $signed({1'b0, bus.in_mag});
      conv_data = v[OUT_W-1:0];
      conv_sat  = 1'b0;
      if (v > MAX_V) begin
         conv_data = {1'b0, {(OUT_W-1){1'b1}}};
         conv_sat  = 1'b1;
      end else if (v < MIN_V) begin
         conv_data = {1'b1, {(OUT_W-1){1'b0}}};
         conv_sat  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= conv_data;
         sat_mem[wr_ptr]  <= conv_sat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         sat_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
         if (push && conv_sat && sat_count != 16'hFFFF)
            sat_count <= sat_count + 1'b1;
      end
   end
endmodule
